// File: rtl/rv32i_alu_arbiter.sv
// Round-robin arbiter sharing one RV32I add/sub ALU between NUM_REQ requesters.
// Each operation runs IDLE -> EXEC -> RESP; results are held until the owner accepts.

module rv32i_alu #(
    parameter int unsigned OP_W = 4
) (
    input  logic [31:0]     i_a,
    input  logic [31:0]     i_b,
    input  logic [OP_W-1:0] i_op,
    output logic [31:0]     o_y
);
    localparam logic [OP_W-1:0] ADD_alu = '0;

    assign o_y = (i_op == ADD_alu) ? (i_a + i_b) : (i_a - i_b);
endmodule

module rv32i_alu_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    input  logic [NUM_REQ*4-1:0]    req_op,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [31:0]             rsp_data,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    op_count
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_rst_q;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       r_owner;
    logic [DATA_W-1:0]      r_a;
    logic [DATA_W-1:0]      r_b;
    logic [OP_W-1:0]        r_op;
    logic [DATA_W-1:0]      r_rsp_data;
    logic [CNT_WIDTH-1:0]   r_op_count;

    logic                   w_found;
    logic [PTR_W-1:0]       w_grant_idx;
    logic                   w_grant_en;
    logic                   w_done;
    logic [DATA_W-1:0]      w_alu_y;

    rv32i_alu #(.OP_W(OP_W)) u_alu (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_y  (w_alu_y)
    );

    // Round-robin search upward from r_rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            logic [PTR_W-1:0] cand;
            cand = PTR_W'((32'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid[cand]) begin
                w_found     = 1'b1;
                w_grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Grants are held off while reset is high and for the cycle after it.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_done      = 1'b0;
        req_ready   = '0;
        rsp_valid   = '0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && !r_rst_q && !rst) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (rsp_ready[r_owner]) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_grant_en)
            req_ready[w_grant_idx] = 1'b1;
        if (r_state == RESP && !rst)
            rsp_valid[r_owner] = 1'b1;
        busy = (r_state != IDLE) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_q    <= 1'b1;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_rsp_data <= '0;
            r_op_count <= '0;
        end else begin
            r_rst_q <= 1'b0;
            if (w_grant_en) begin
                r_a     <= req_a[DATA_W*w_grant_idx +: DATA_W];
                r_b     <= req_b[DATA_W*w_grant_idx +: DATA_W];
                r_op    <= req_op[OP_W*w_grant_idx +: OP_W];
                r_owner <= w_grant_idx;
            end
            if (r_state == EXEC)
                r_rsp_data <= w_alu_y;
            // Completion advances the pointer past the owner; the counter saturates.
            if (w_done) begin
                r_rr_ptr <= PTR_W'((32'(r_owner) + 32'd1) % NUM_REQ);
                if (r_op_count != {CNT_WIDTH{1'b1}})
                    r_op_count <= r_op_count + CNT_WIDTH'(1);
            end
        end
    end

    assign rsp_data = r_rsp_data;
    assign op_count = r_op_count;
endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// Directed bench for rv32i_alu_arbiter with two requesters and a 2-bit counter.
`timescale 1ns/1ps

module tb_rv32i_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic [1:0]  op_count;

    int n_chk = 0;
    int n_bad = 0;

    rv32i_alu_arbiter #(.NUM_REQ(2), .CNT_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One request from idx; operands are trashed right after capture.
    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] exp, input logic [1:0] exp_cnt);
        logic [1:0] oh;
        oh = 2'b00;
        oh[idx] = 1'b1;
        @(negedge clk);
        req_valid = oh;
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        req_op[4*idx +: 4]  = op;
        rsp_ready = 2'b11;
        #1 chk("op_grant", 64'(req_ready), 64'(oh));
        @(negedge clk);
        req_valid = 2'b00;
        req_a  = '1;
        req_b  = 64'h1234_5678_9abc_def0;
        req_op = 8'h11;
        #1 chk("op_exec_busy", 64'(busy), 64'd1);
        chk("op_exec_rspv", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        #1 chk("op_rspv", 64'(rsp_valid), 64'(oh));
        chk("op_data", 64'(rsp_data), 64'(exp));
        @(negedge clk);
        #1 chk("op_idle", 64'(busy), 64'd0);
        chk("op_count", 64'(op_count), 64'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        req_a = '0; req_b = '0; req_op = '0;

        // Outputs quiet while reset is asserted, even with requests pending.
        repeat (2) @(negedge clk);
        #1 chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        @(negedge clk);
        #1 chk("rst_count", 64'(op_count), 64'd0);
        chk("rst_data", 64'(rsp_data), 64'd0);

        do_op(0, 32'h0000_0005, 32'h0000_0003, OP_ADD, 32'h0000_0008, 2'd1);
        do_op(0, 32'h0000_0000, 32'h0000_0001, OP_SUB, 32'hFFFF_FFFF, 2'd2);
        do_op(1, 32'hFFFF_FFFF, 32'h0000_0002, OP_ADD, 32'h0000_0001, 2'd3);
        do_op(0, 32'd10,        32'd3,         4'd7,   32'd7,         2'd3);

        // Contention after reset: pointer was left at 1, reset must restart at 0.
        do_reset();
        @(negedge clk);
        req_a  = {32'd50, 32'd100};
        req_b  = {32'd20, 32'd1};
        req_op = {OP_SUB, OP_ADD};
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("cont_grant", 64'(req_ready), (k % 2 == 1) ? 64'd2 : 64'd1);
            @(negedge clk);
            @(negedge clk);
            #1 chk("cont_rspv", 64'(rsp_valid), (k % 2 == 1) ? 64'd2 : 64'd1);
            chk("cont_data", 64'(rsp_data), (k % 2 == 1) ? 64'd30 : 64'd101);
            @(negedge clk);
        end
        req_valid = 2'b00;

        // Back-pressure on requester 1 while requester 0 waits.
        @(negedge clk);
        req_a[63:32] = 32'd7; req_b[63:32] = 32'd9; req_op[7:4] = OP_ADD;
        req_valid = 2'b10; rsp_ready = 2'b00;
        #1 chk("bp_grant", 64'(req_ready), 64'd2);
        @(negedge clk);
        req_valid = 2'b01;
        #1 chk("bp_exec_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_rspv", 64'(rsp_valid), 64'd2);
            chk("bp_data", 64'(rsp_data), 64'd16);
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_ready", 64'(req_ready), 64'd0);
            rsp_ready = 2'b01;
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        #1 chk("bp_next_grant", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1 chk("bp_next_data", 64'(rsp_data), 64'd101);
        chk("bp_next_rspv", 64'(rsp_valid), 64'd1);
        rsp_ready = 2'b11;
        @(negedge clk);

        // Reset while an operation is in EXEC.
        do_reset();
        do_op(0, 32'd1, 32'd1, OP_ADD, 32'd2, 2'd1);
        @(negedge clk);
        req_a[31:0] = 32'd3; req_b[31:0] = 32'd4; req_op[3:0] = OP_ADD;
        req_valid = 2'b01;
        #1 chk("mid_grant", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rspv", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_after_busy", 64'(busy), 64'd0);
        chk("mid_after_rspv", 64'(rsp_valid), 64'd0);
        chk("mid_after_count", 64'(op_count), 64'd0);
        chk("mid_after_data", 64'(rsp_data), 64'd0);
        chk("mid_after_ready", 64'(req_ready), 64'd0);
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk("mid_no_stale", 64'(rsp_valid), 64'd0);
        end

        // Saturation of the 2-bit counter.
        do_reset();
        for (int k = 0; k < 5; k++)
            do_op(k % 2, 32'(k), 32'd1, OP_ADD, 32'(k + 1), (k >= 2) ? 2'd3 : 2'(k + 1));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
